// File: rtl/demux_1x2_reg_if.sv
// rtl/demux_1x2_reg_if.sv - handshake bundle for the registered 1-to-2 demultiplexer
//
// Purpose: groups the producer port, both consumer ports and the per-channel
//   transfer counters of demux_1x2_reg into one interface.
// Optional feature macro: DEMUX_ALTERNATE_EN adds the ALT input.
// Signals:
//   D / D_valid / D_ready     producer word offer and acceptance
//   S                         channel select (0 = A, 1 = B)
//   E                         active-low enable (E=1 blocks acceptance)
//   YA / YA_valid / YA_ready  channel A holding register and handshake
//   YB / YB_valid / YB_ready  channel B holding register and handshake
//   cnt_A / cnt_B             words accepted per channel, wrapping
//   ALT                       (DEMUX_ALTERNATE_EN only) alternate A/B routing
// Modports: slave = the demultiplexer, master = producer/consumer side.
interface demux_1x2_reg_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] D;
  logic             D_valid;
  logic             D_ready;
  logic             S;
  logic             E;
  logic [WIDTH-1:0] YA;
  logic             YA_valid;
  logic             YA_ready;
  logic [WIDTH-1:0] YB;
  logic             YB_valid;
  logic             YB_ready;
  logic [CNT_W-1:0] cnt_A;
  logic [CNT_W-1:0] cnt_B;
`ifdef DEMUX_ALTERNATE_EN
  logic             ALT;
`endif

  modport slave (
`ifdef DEMUX_ALTERNATE_EN
    input  ALT,
`endif
    input  D, D_valid, S, E, YA_ready, YB_ready,
    output D_ready, YA, YA_valid, YB, YB_valid, cnt_A, cnt_B
  );

  modport master (
`ifdef DEMUX_ALTERNATE_EN
    output ALT,
`endif
    output D, D_valid, S, E, YA_ready, YB_ready,
    input  D_ready, YA, YA_valid, YB, YB_valid, cnt_A, cnt_B
  );
endinterface

// File: rtl/demux_1x2_reg.sv
// rtl/demux_1x2_reg.sv - registered 1-to-2 demultiplexer with valid/ready on every port
//
// Purpose: routes each accepted input word into the one-word holding register
//   of channel A (S=0) or channel B (S=1); each channel keeps a wrapping count
//   of accepted words. A channel can take a new word in the same cycle its
//   current word drains, giving one word per cycle per channel.
// Optional feature macro: DEMUX_ALTERNATE_EN - adds ALT; with ALT=1 the target
//   channel comes from an internal toggle that flips on every accept (A,B,A,...).
// Ports:
//   CLK      clock, rising edge
//   reset_b  synchronous active-low reset
//   bus      demux_1x2_reg_if.slave (D/D_valid/D_ready, S, E, YA/YB handshakes,
//            cnt_A/cnt_B, ALT when enabled)
module demux_1x2_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic           CLK,
  input logic           reset_b,
  demux_1x2_reg_if.slave bus
);

  logic [WIDTH-1:0] r_ya;
  logic [WIDTH-1:0] r_yb;
  logic             r_ya_valid;
  logic             r_yb_valid;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  logic w_tgt;
  logic w_ya_free;
  logic w_yb_free;
  logic w_d_ready;
  logic w_accept;
  logic w_acc_a;
  logic w_acc_b;
  logic w_drain_a;
  logic w_drain_b;

`ifdef DEMUX_ALTERNATE_EN
  logic r_tgl;
  assign w_tgt = bus.ALT ? r_tgl : bus.S;
`else
  assign w_tgt = bus.S;
`endif

  // A channel can take a word if it is empty or its word leaves this cycle.
  assign w_ya_free = ~r_ya_valid | bus.YA_ready;
  assign w_yb_free = ~r_yb_valid | bus.YB_ready;
  assign w_d_ready = ~bus.E & (w_tgt ? w_yb_free : w_ya_free);
  assign w_accept  = bus.D_valid & w_d_ready;
  assign w_acc_a   = w_accept & ~w_tgt;
  assign w_acc_b   = w_accept & w_tgt;
  assign w_drain_a = r_ya_valid & bus.YA_ready;
  assign w_drain_b = r_yb_valid & bus.YB_ready;

  always_ff @(posedge CLK) begin
    if (!reset_b) begin
      r_ya       <= '0;
      r_yb       <= '0;
      r_ya_valid <= 1'b0;
      r_yb_valid <= 1'b0;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
    end else begin
      // Accept wins over drain: a simultaneous drain+accept keeps valid high.
      if (w_acc_a) begin
        r_ya       <= bus.D;
        r_ya_valid <= 1'b1;
        r_cnt_a    <= r_cnt_a + 1'b1;
      end else if (w_drain_a) begin
        r_ya_valid <= 1'b0;
      end
      if (w_acc_b) begin
        r_yb       <= bus.D;
        r_yb_valid <= 1'b1;
        r_cnt_b    <= r_cnt_b + 1'b1;
      end else if (w_drain_b) begin
        r_yb_valid <= 1'b0;
      end
    end
  end

`ifdef DEMUX_ALTERNATE_EN
  always_ff @(posedge CLK) begin
    if (!reset_b) begin
      r_tgl <= 1'b0;
    end else if (bus.ALT && w_accept) begin
      r_tgl <= ~r_tgl;
    end
  end
`endif

  assign bus.D_ready  = w_d_ready;
  assign bus.YA       = r_ya;
  assign bus.YA_valid = r_ya_valid;
  assign bus.YB       = r_yb;
  assign bus.YB_valid = r_yb_valid;
  assign bus.cnt_A    = r_cnt_a;
  assign bus.cnt_B    = r_cnt_b;

endmodule
